seg7_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment display controller. Drives NUM_DIGITS common-anode digits directly from CLK100_IN.
- Adds double-buffered digit loading (no tearing), anti-ghosting guard band, PWM brightness, per-digit blink/blank and leading-zero suppression.
- Generates the system tick (tick_out) used by demo/status logic.
- Sits between the application logic and the board seven-segment pins. Replaces the fixed 4-digit select+decoder path.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_tick_gen.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active low, bit order gfedcba.
package seg7_pkg;

  localparam logic [7:0] HEX_BLANK = 8'hFF;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       dot;
    logic       blank;
    logic       blink;
  } digit_cfg_t;

  localparam digit_cfg_t CFG_RST = '{nibble: 4'h0, dot: 1'b0, blank: 1'b1, blink: 1'b0};

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running modulo-DIV counter; the parent derives its wrap/tick from cnt.
module seg7_tick_gen #(
  parameter  int unsigned DIV = 2,
  localparam int unsigned W   = $clog2(DIV)
) (
  input  logic         CLK100_IN,
  input  logic         rst_n,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (cnt == W'(DIV-1))  cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with double-buffered digit data,
// guard band, PWM brightness, blink/blank and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SLOT_CYC   = 100000,
  parameter int unsigned GUARD_CYC  = 200,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                    CLK100_IN,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dot_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    tick_out,
  output logic                    frame_done
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SLOT_W = $clog2(SLOT_CYC);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic [SLOT_W-1:0] slot_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              slot_wrap, tick_wrap, last_digit, frame_bnd;

  seg7_tick_gen #(.DIV(SLOT_CYC)) u_slot (.CLK100_IN(CLK100_IN), .rst_n(rst_n), .cnt(slot_cnt));
  seg7_tick_gen #(.DIV(TICK_DIV)) u_tick (.CLK100_IN(CLK100_IN), .rst_n(rst_n), .cnt(tick_cnt));

  logic [IDX_W-1:0]    digit_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase, fd_pre;

  digit_cfg_t [NUM_DIGITS-1:0] load_cfg, stg_cfg, act_cfg;
  logic                        stg_lz, act_lz;
  logic [PWM_BITS-1:0]         stg_br, act_br;

  assign slot_wrap  = (slot_cnt == SLOT_W'(SLOT_CYC-1));
  assign tick_wrap  = (tick_cnt == TICK_W'(TICK_DIV-1));
  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS-1));
  assign frame_bnd  = slot_wrap & last_digit;

  always_comb begin
    load_cfg = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      load_cfg[i] = '{nibble: digit_data[4*i +: 4], dot: dot_in[i],
                      blank: blank_in[i], blink: blink_en[i]};
  end

  // A digit is suppressed while every digit from the top down to it is a bare zero.
  logic [NUM_DIGITS-1:0] supp;
  logic                  lz_run;
  always_comb begin
    supp   = '0;
    lz_run = act_lz;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      lz_run  = lz_run & (act_cfg[i].nibble == 4'h0) & ~act_cfg[i].dot;
      supp[i] = lz_run;
    end
  end

  digit_cfg_t cur;
  logic       in_win, pwm_on, digit_dark, lit;
  assign cur        = act_cfg[digit_idx];
  assign in_win     = (slot_cnt >= SLOT_W'(GUARD_CYC));
  assign pwm_on     = (&act_br) | (pwm_cnt < act_br);
  assign digit_dark = cur.blank | (cur.blink & ~blink_phase) | supp[digit_idx];
  assign lit        = in_win & pwm_on & ~digit_dark;

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx   <= '0;
      pwm_cnt     <= '0;
      blink_phase <= 1'b1;
      tick_out    <= 1'b0;
      fd_pre      <= 1'b0;
      frame_done  <= 1'b0;
      stg_cfg     <= {NUM_DIGITS{CFG_RST}};
      act_cfg     <= {NUM_DIGITS{CFG_RST}};
      stg_lz      <= 1'b0;
      act_lz      <= 1'b0;
      stg_br      <= '0;
      act_br      <= '0;
    end else begin
      tick_out <= tick_wrap;
      if (tick_out) blink_phase <= ~blink_phase;
      // frame_done lines up with the first registered output of the new frame
      fd_pre     <= frame_bnd;
      frame_done <= fd_pre;
      pwm_cnt    <= (slot_wrap || !in_win) ? '0 : pwm_cnt + 1'b1;
      if (slot_wrap) digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
      if (frame_bnd) begin
        act_cfg <= stg_cfg;
        act_lz  <= stg_lz;
        act_br  <= stg_br;
      end
      if (load) begin
        stg_cfg <= load_cfg;
        stg_lz  <= lz_suppress;
        stg_br  <= brightness;
      end
    end
  end

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      SEG_SELECT_OUT <= NUM_DIGITS'(ANODE_OFF);
      HEX_OUT        <= HEX_BLANK;
    end else if (lit) begin
      SEG_SELECT_OUT <= ~(NUM_DIGITS'(1) << digit_idx);
      HEX_OUT        <= {~cur.dot, seg_encode(cur.nibble)};
    end else begin
      SEG_SELECT_OUT <= NUM_DIGITS'(ANODE_OFF);
      HEX_OUT        <= HEX_BLANK;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a closed-form reference model pushes the expected output of
// every clock edge; scenario tasks pop and compare at the following negedge.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digit_data;
  logic [3:0]  dot_in, blank_in, blink_en;
  logic        lz_suppress, load;
  logic [1:0]  brightness;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        tick_out, frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYC(20), .GUARD_CYC(2), .PWM_BITS(2), .TICK_DIV(50)) dut (
    .CLK100_IN(clk), .rst_n(rst_n), .digit_data(digit_data), .dot_in(dot_in),
    .blank_in(blank_in), .blink_en(blink_en), .lz_suppress(lz_suppress),
    .brightness(brightness), .load(load), .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .HEX_OUT(HEX_OUT), .tick_out(tick_out), .frame_done(frame_done)
  );

  localparam logic [7:0] LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct { logic [3:0] sel; logic [7:0] hex; logic tick; logic fd; } exp_t;
  typedef struct { logic [15:0] data; logic [3:0] dot, blank, blink; logic lz; logic [1:0] br; } cfg_t;

  exp_t sbq[$];
  cfg_t m_stg, m_act;
  int   kcnt;

  function automatic cfg_t cfg_reset();
    cfg_t c;
    c = '{data: 16'h0, dot: 4'h0, blank: 4'hF, blink: 4'h0, lz: 1'b0, br: 2'd0};
    return c;
  endfunction

  // Expected outputs after the edge that follows k completed edges since reset release.
  function automatic exp_t model_out(int k, cfg_t c);
    exp_t e;
    int slot, dig, pwm, nt;
    logic phase, sup, lit;
    logic [3:0] nib;
    slot  = k % 20;
    dig   = (k / 20) % 4;
    pwm   = (slot >= 2) ? (slot - 2) % 4 : 0;
    nt    = (k >= 1) ? (k - 1) / 50 : 0;
    phase = (nt % 2) == 0;
    sup   = c.lz && (dig > 0);
    for (int j = 3; j >= dig; j--)
      if (c.data[4*j +: 4] != 4'h0 || c.dot[j]) sup = 1'b0;
    nib = c.data[4*dig +: 4];
    lit = (slot >= 2) && (c.br == 2'd3 || pwm < int'(c.br)) && !c.blank[dig]
          && !(c.blink[dig] && !phase) && !sup;
    e.sel  = lit ? ~(4'b0001 << dig) : 4'hF;
    e.hex  = lit ? (LUT[nib] & (c.dot[dig] ? 8'h7F : 8'hFF)) : 8'hFF;
    e.tick = ((k + 1) % 50) == 0;
    e.fd   = (k > 0) && (k % 80 == 0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt  <= 0;
      m_stg <= cfg_reset();
      m_act <= cfg_reset();
    end else begin
      sbq.push_back(model_out(kcnt, m_act));
      if (kcnt % 80 == 79) m_act <= m_stg;
      if (load) m_stg <= '{data: digit_data, dot: dot_in, blank: blank_in,
                           blink: blink_en, lz: lz_suppress, br: brightness};
      kcnt <= kcnt + 1;
    end
  end

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl,
                            input logic [3:0] bk, input logic lz, input logic [1:0] br);
    digit_data = d; dot_in = dt; blank_in = bl; blink_en = bk; lz_suppress = lz; brightness = br;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0;
    set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    checks++; if (SEG_SELECT_OUT !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=F", SEG_SELECT_OUT); end
    checks++; if (HEX_OUT !== 8'hFF) begin errors++; $display("FAIL reset_hex got=%h exp=FF", HEX_OUT); end
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    exp_t e;
    int nticks = 0, nfd = 0;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); e = sbq.pop_front();
      nticks += int'(tick_out); nfd += int'(frame_done);
      checks++;
      if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex || tick_out !== e.tick || frame_done !== e.fd) begin
        errors++;
        $display("FAIL idle k=%0d sel=%h/%h hex=%h/%h tick=%b/%b fd=%b/%b", kcnt,
                 SEG_SELECT_OUT, e.sel, HEX_OUT, e.hex, tick_out, e.tick, frame_done, e.fd);
      end
    end
    checks++; if (nticks != 10) begin errors++; $display("FAIL idle_tick_count got=%0d exp=10", nticks); end
    checks++; if (nfd != 6) begin errors++; $display("FAIL idle_fd_count got=%0d exp=6", nfd); end
  endtask

  task automatic test_digits(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bk,
                             input logic lz, input int ncyc);
    exp_t e;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk); e = sbq.pop_front();
      checks++;
      if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex || tick_out !== e.tick || frame_done !== e.fd) begin
        errors++;
        $display("FAIL digits d=%h k=%0d sel=%h/%h hex=%h/%h tick=%b/%b fd=%b/%b", d, kcnt,
                 SEG_SELECT_OUT, e.sel, HEX_OUT, e.hex, tick_out, e.tick, frame_done, e.fd);
      end
      if (i == 0) begin set_inputs(d, dt, 4'h0, bk, lz, 2'd3); load = 1'b1; end
      else load = 1'b0;
    end
  endtask

  task automatic test_pwm(input logic [1:0] br, input int exp_lit);
    exp_t e;
    int nfd = 0, win = -1, nlit = 0;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < 320; i++) begin
      @(negedge clk); e = sbq.pop_front();
      checks++;
      if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex || tick_out !== e.tick || frame_done !== e.fd) begin
        errors++;
        $display("FAIL pwm br=%0d k=%0d sel=%h/%h hex=%h/%h tick=%b/%b fd=%b/%b", br, kcnt,
                 SEG_SELECT_OUT, e.sel, HEX_OUT, e.hex, tick_out, e.tick, frame_done, e.fd);
      end
      if (frame_done === 1'b1) begin nfd++; if (nfd == 2) win = 0; end
      if (win >= 0 && win < 80) begin
        if (SEG_SELECT_OUT !== 4'hF) nlit++;
        win++;
      end
      if (i == 0) begin set_inputs(16'h08AC, 4'h0, 4'h0, 4'h0, 1'b0, br); load = 1'b1; end
      else load = 1'b0;
    end
    checks++;
    if (win != 80 || nlit != exp_lit) begin
      errors++; $display("FAIL pwm_lit_count br=%0d got=%0d exp=%0d window=%0d", br, nlit, exp_lit, win);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int stage = 0, nsamp = 0;
    logic [7:0] samp [2];
    samp[0] = 8'h00; samp[1] = 8'h00;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < 320; i++) begin
      @(negedge clk); e = sbq.pop_front();
      checks++;
      if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex || tick_out !== e.tick || frame_done !== e.fd) begin
        errors++;
        $display("FAIL b2b k=%0d sel=%h/%h hex=%h/%h tick=%b/%b fd=%b/%b", kcnt,
                 SEG_SELECT_OUT, e.sel, HEX_OUT, e.hex, tick_out, e.tick, frame_done, e.fd);
      end
      if (stage == 3 && kcnt % 80 == 5 && nsamp < 2) begin samp[nsamp] = HEX_OUT; nsamp++; end
      load = 1'b0;
      if (stage == 0 && kcnt % 80 == 10) begin
        set_inputs(16'h3333, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3); load = 1'b1; stage = 1;
      end else if (stage == 1 && kcnt % 80 == 30) begin
        set_inputs(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3); load = 1'b1; stage = 2;
      end else if (stage == 2 && kcnt % 80 == 79) begin
        set_inputs(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3); load = 1'b1; stage = 3;
      end
    end
    checks++; if (nsamp != 2 || samp[0] !== 8'hA4) begin errors++; $display("FAIL b2b_first_frame got=%h exp=A4 samples=%0d", samp[0], nsamp); end
    checks++; if (nsamp != 2 || samp[1] !== 8'hF9) begin errors++; $display("FAIL b2b_second_frame got=%h exp=F9 samples=%0d", samp[1], nsamp); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int found = 0;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk); void'(sbq.pop_front());
      if (kcnt % 20 == 10) found = 1;
    end
    @(posedge clk); #2;
    e = sbq[sbq.size()-1];
    checks++;
    if (found == 0 || SEG_SELECT_OUT !== e.sel || e.sel === 4'hF) begin
      errors++; $display("FAIL pre_reset_lit got=%h exp=%h found=%0d", SEG_SELECT_OUT, e.sel, found);
    end
    rst_n = 1'b0; #1;
    checks++; if (SEG_SELECT_OUT !== 4'hF) begin errors++; $display("FAIL async_sel got=%h exp=F", SEG_SELECT_OUT); end
    checks++; if (HEX_OUT !== 8'hFF) begin errors++; $display("FAIL async_hex got=%h exp=FF", HEX_OUT); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); sbq.delete();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); e = sbq.pop_front();
      checks++;
      if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex || tick_out !== e.tick || frame_done !== e.fd) begin
        errors++;
        $display("FAIL after_reset k=%0d sel=%h/%h hex=%h/%h tick=%b/%b fd=%b/%b", kcnt,
                 SEG_SELECT_OUT, e.sel, HEX_OUT, e.hex, tick_out, e.tick, frame_done, e.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_digits(16'h08AC, 4'b1010, 4'h0, 1'b0, 240);
    test_pwm(2'd1, 20);
    test_pwm(2'd0, 0);
    test_digits(16'h0005, 4'h0, 4'h0, 1'b1, 200);
    test_digits(16'h0005, 4'h0, 4'h0, 1'b0, 200);
    test_digits(16'h08AC, 4'h0, 4'b0001, 1'b0, 300);
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
